wave_display_mc: RTL and testbench

Multi-channel, parametrised waveform renderer between the sample RAM and the pixel pipeline. For each incoming pixel coordinate it drives a shared read address, aligns the returned samples of NUM_CH channels to the pixel, and reports whether the pixel lies on any channel's trace. The trace is drawn as connected vertical segments between consecutive samples. Adds per-channel enable, priority colouring, configurable window, zoom and RAM latency, and a per-frame bank latch.

---
 rtl/wave_pkg.sv | 26 ++
 rtl/wave_display_mc_if.sv | 29 ++
 rtl/wave_channel_tracker.sv | 59 +++++
 rtl/wave_display_mc.sv | 118 +++++++++++
 tb/tb_wave_display_mc.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wave_pkg.sv
// Shared constants for the multi-channel waveform renderer: channel limits,
// read-latency bounds and the per-channel trace palette.
package wave_pkg;

  localparam int unsigned MAX_CH     = 4;
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 3;

  typedef logic [23:0] rgb_t;

  localparam rgb_t COL_WHITE   = 24'hFF_FF_FF;
  localparam rgb_t COL_YELLOW  = 24'hFF_FF_00;
  localparam rgb_t COL_CYAN    = 24'h00_FF_FF;
  localparam rgb_t COL_MAGENTA = 24'hFF_00_FF;

  // Trace colour for a channel index; channel 0 has the highest priority.
  function automatic rgb_t ch_colour(input int unsigned ch);
    case (ch)
      0:       return COL_WHITE;
      1:       return COL_YELLOW;
      2:       return COL_CYAN;
      default: return COL_MAGENTA;
    endcase
  endfunction

endpackage

// File: rtl/wave_display_mc_if.sv
// Pixel-in / sample-RAM / pixel-out bus of the waveform renderer.
interface wave_display_mc_if #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned ADDR_W   = 8
);
  logic [10:0]                x;
  logic [9:0]                 y;
  logic                       valid;
  logic                       read_index;
  logic [NUM_CH-1:0]          ch_enable;
  logic [ADDR_W:0]            read_address;
  logic [NUM_CH*SAMPLE_W-1:0] read_value;
  logic                       valid_pixel;
  logic [7:0]                 r;
  logic [7:0]                 g;
  logic [7:0]                 b;
  logic [NUM_CH-1:0]          hit_ch;

  modport master (
    output x, y, valid, read_index, ch_enable, read_value,
    input  read_address, valid_pixel, r, g, b, hit_ch
  );

  modport slave (
    input  x, y, valid, read_index, ch_enable, read_value,
    output read_address, valid_pixel, r, g, b, hit_ch
  );
endinterface

// File: rtl/wave_channel_tracker.sv
// One channel's trace state: keeps the previous and current adjusted
// samples along a line and flags pixels lying on the segment between them.
module wave_channel_tracker #(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned V_SHIFT  = 1,
  parameter int unsigned V_OFFSET = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                in_win,
  input  logic [ADDR_W-1:0]   idx,
  input  logic [SAMPLE_W-1:0] row,
  input  logic [SAMPLE_W-1:0] raw,
  output logic                hit
);
  logic [SAMPLE_W-1:0] prev, curr, prev_n, curr_n, adj, lo, hi;
  logic [ADDR_W-1:0]   last_idx;
  logic                last_in_win;

  // Next prev/curr (line start reloads both, new index shifts) and hit test.
  always_comb begin
    adj    = SAMPLE_W'(32'(raw >> V_SHIFT) + V_OFFSET);
    prev_n = prev;
    curr_n = curr;
    if (in_win && !last_in_win) begin
      prev_n = adj;
      curr_n = adj;
    end else if (in_win && (idx != last_idx)) begin
      prev_n = curr;
      curr_n = adj;
    end
    if (prev_n < curr_n) begin
      lo = prev_n;
      hi = curr_n;
    end else begin
      lo = curr_n;
      hi = prev_n;
    end
    hit = enable && in_win && (row >= lo) && (row <= hi);
  end

  // Trace state registers; index memory only advances inside the window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev        <= '0;
      curr        <= '0;
      last_idx    <= '0;
      last_in_win <= 1'b0;
    end else begin
      prev        <= prev_n;
      curr        <= curr_n;
      last_in_win <= in_win;
      if (in_win) last_idx <= idx;
    end
  end

endmodule

// File: rtl/wave_display_mc.sv
// Multi-channel waveform renderer: window decode, per-frame bank latch,
// RAM-latency alignment pipeline, per-channel trackers and priority colour.
module wave_display_mc
  import wave_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned X0       = 256,
  parameter int unsigned Y0       = 0,
  parameter int unsigned X_SHIFT  = 1,
  parameter int unsigned Y_SHIFT  = 1,
  parameter int unsigned V_SHIFT  = 1,
  parameter int unsigned V_OFFSET = 32,
  parameter int unsigned RD_LAT   = 1
) (
  input logic          clk,
  input logic          reset_n,
  wave_display_mc_if.slave bus
);
  localparam int unsigned X_SPAN = 1 << (ADDR_W + X_SHIFT);
  localparam int unsigned Y_SPAN = 1 << (SAMPLE_W + Y_SHIFT);

  logic [31:0]         dx, dy;
  logic                in_win;
  logic [ADDR_W-1:0]   idx;
  logic [SAMPLE_W-1:0] row;
  logic                bank;

  logic                win_q [RD_LAT];
  logic [ADDR_W-1:0]   idx_q [RD_LAT];
  logic [SAMPLE_W-1:0] row_q [RD_LAT];

  logic [NUM_CH-1:0]   hit_c;
  rgb_t                colour;
  logic                found;

  // Window decode; offsets below the window edge wrap large and fail the span test.
  always_comb begin
    dx     = 32'(bus.x) - X0;
    dy     = 32'(bus.y) - Y0;
    in_win = bus.valid && (dx < X_SPAN) && (dy < Y_SPAN);
    idx    = in_win ? ADDR_W'(dx >> X_SHIFT) : '0;
    row    = SAMPLE_W'(dy >> Y_SHIFT);
  end

  assign bus.read_address = {bank, idx};

  // Bank select is sampled only on the frame's first pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bank <= 1'b0;
    else if (bus.valid && (bus.x == '0) && (bus.y == '0)) bank <= bus.read_index;
  end

  // Delay pixel attributes to meet the RAM data RD_LAT cycles later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        win_q[i] <= 1'b0;
        idx_q[i] <= '0;
        row_q[i] <= '0;
      end
    end else begin
      win_q[0] <= in_win;
      idx_q[0] <= idx;
      row_q[0] <= row;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        win_q[i] <= win_q[i-1];
        idx_q[i] <= idx_q[i-1];
        row_q[i] <= row_q[i-1];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    wave_channel_tracker #(
      .SAMPLE_W (SAMPLE_W),
      .ADDR_W   (ADDR_W),
      .V_SHIFT  (V_SHIFT),
      .V_OFFSET (V_OFFSET)
    ) u_trk (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (bus.ch_enable[c]),
      .in_win  (win_q[RD_LAT-1]),
      .idx     (idx_q[RD_LAT-1]),
      .row     (row_q[RD_LAT-1]),
      .raw     (bus.read_value[c*SAMPLE_W +: SAMPLE_W]),
      .hit     (hit_c[c])
    );
  end

  // Lowest-numbered hit channel picks the colour.
  always_comb begin
    colour = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (hit_c[i] && !found) begin
        colour = ch_colour(i);
        found  = 1'b1;
      end
    end
  end

  // Registered pixel result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.valid_pixel         <= 1'b0;
      {bus.r, bus.g, bus.b}   <= '0;
      bus.hit_ch              <= '0;
    end else begin
      bus.valid_pixel         <= |hit_c;
      {bus.r, bus.g, bus.b}   <= colour;
      bus.hit_ch              <= hit_c;
    end
  end

endmodule

// File: tb/tb_wave_display_mc.sv
// Bench for wave_display_mc: RAM model with read latency, and a pixel-level
// reference that derives each pixel's lit state from the sample indices on
// the current line.
module tb_wave_display_mc;
  localparam int NCH = 2;
  localparam int SW  = 8;
  localparam int AW  = 8;
  localparam int X0  = 256;
  localparam int Y0  = 0;
  localparam int XS  = 1;
  localparam int YS  = 1;
  localparam int VS  = 1;
  localparam int VO  = 32;
  localparam int LAT = 3;

  typedef struct packed {
    logic           vp;
    logic [23:0]    rgb;
    logic [NCH-1:0] hit;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  wave_display_mc_if #(.NUM_CH(NCH), .SAMPLE_W(SW), .ADDR_W(AW)) bus ();

  wave_display_mc #(
    .NUM_CH(NCH), .SAMPLE_W(SW), .ADDR_W(AW), .X0(X0), .Y0(Y0),
    .X_SHIFT(XS), .Y_SHIFT(YS), .V_SHIFT(VS), .V_OFFSET(VO), .RD_LAT(LAT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [SW-1:0] ram [NCH][2][1<<AW];
  logic [AW:0]   addr_hist [LAT];
  exp_t          exp_q [$];
  int            checks = 0;
  int            errors = 0;
  bit            mdl_bank;
  bit            run_active;
  int            prev_idx, cur_idx;

  function automatic int adj(input logic [SW-1:0] s);
    return ((int'(s) >> VS) + VO) % (1 << SW);
  endfunction

  function automatic logic [23:0] colour_of(input int c);
    case (c)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      default: return 24'hFF00FF;
    endcase
  endfunction

  function automatic logic [NCH*SW-1:0] ram_word(input logic [AW:0] a);
    logic [NCH*SW-1:0] w;
    for (int c = 0; c < NCH; c++) w[c*SW +: SW] = ram[c][a[AW]][a[AW-1:0]];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vp"},  32'(bus.valid_pixel), 32'd0);
    chk({tag, "_rgb"}, 32'({bus.r, bus.g, bus.b}), 32'd0);
    chk({tag, "_hit"}, 32'(bus.hit_ch), 32'd0);
  endtask

  task automatic reset_model();
    exp_t e;
    e = '0;
    exp_q.delete();
    for (int i = 0; i < LAT; i++) exp_q.push_back(e);
    mdl_bank   = 1'b0;
    run_active = 1'b0;
  endtask

  // Reference: a pixel is lit when its row unit lies between the adjusted
  // samples at the previous distinct index and the current index of this
  // window run (a fresh run uses only the current sample).
  task automatic model_issue(input int nx, input int ny, input bit nv, output logic [AW:0] ea);
    bit   inwin, found;
    int   idx, row, a, b, lo, hi;
    exp_t e;
    inwin = nv && nx >= X0 && nx < X0 + (1 << (AW + XS)) &&
            ny >= Y0 && ny < Y0 + (1 << (SW + YS));
    idx = inwin ? (nx - X0) >> XS : 0;
    ea  = {mdl_bank, 8'(idx)};
    if (inwin) begin
      if (!run_active) begin
        prev_idx = idx;
        cur_idx  = idx;
      end else if (idx != cur_idx) begin
        prev_idx = cur_idx;
        cur_idx  = idx;
      end
    end
    run_active = inwin;
    row   = (ny - Y0) >> YS;
    e     = '0;
    found = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      a  = adj(ram[c][mdl_bank][prev_idx]);
      b  = adj(ram[c][mdl_bank][cur_idx]);
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      if (inwin && bus.ch_enable[c] && row >= lo && row <= hi) begin
        e.hit[c] = 1'b1;
        if (!found) begin
          e.rgb = colour_of(c);
          found = 1'b1;
        end
      end
    end
    e.vp = found;
    if (nv && nx == 0 && ny == 0) mdl_bank = bus.read_index;
    exp_q.push_back(e);
  endtask

  // One pixel cycle: drive inputs, serve RAM data, check address, then outputs.
  task automatic step(input int nx, input int ny, input bit nv);
    logic [AW:0] ea;
    exp_t        e;
    bus.x          = 11'(nx);
    bus.y          = 10'(ny);
    bus.valid      = nv;
    bus.read_value = ram_word(addr_hist[LAT-1]);
    model_issue(nx, ny, nv, ea);
    #1;
    chk("read_address", 32'(bus.read_address), 32'(ea));
    for (int i = LAT - 1; i > 0; i--) addr_hist[i] = addr_hist[i-1];
    addr_hist[0] = bus.read_address;
    @(posedge clk);
    #1;
    if (exp_q.size() == LAT + 1) begin
      e = exp_q.pop_front();
      chk("valid_pixel", 32'(bus.valid_pixel), 32'(e.vp));
      chk("rgb", 32'({bus.r, bus.g, bus.b}), 32'(e.rgb));
      chk("hit_ch", 32'(bus.hit_ch), 32'(e.hit));
    end
  endtask

  task automatic line(input int ny, input int xa, input int xb);
    for (int xi = xa; xi <= xb; xi++) step(xi, ny, 1'b1);
  endtask

  task automatic set_en(input logic [NCH-1:0] en);
    for (int i = 0; i < LAT + 1; i++) step(1000, 1000, 1'b0);
    bus.ch_enable = en;
  endtask

  task automatic mid_reset();
    #3 reset_n = 1'b0;
    #1 check_zero("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    reset_model();
    check_zero("rst_release");
    chk("bank_after_rst", 32'(bus.read_address[AW]), 32'd0);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.x          = '0;
    bus.y          = '0;
    bus.valid      = 1'b0;
    bus.read_index = 1'b0;
    bus.ch_enable  = '0;
    bus.read_value = '0;
    for (int i = 0; i < LAT; i++) addr_hist[i] = '0;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < (1 << AW); i++) ram[c][k][i] = 8'($urandom);
    #1 check_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    reset_model();
    check_zero("post_reset");
    chk("bank_reset", 32'(bus.read_address[AW]), 32'd0);

    // Flat trace on ch0, ch1 disabled; window edges 255/256 and 767/768.
    for (int i = 0; i < (1 << AW); i++) ram[0][0][i] = 8'h40;
    set_en(2'b01);
    line(127, 250, 775);
    line(128, 250, 775);
    line(129, 250, 775);
    line(130, 250, 300);

    // Step between sample 10 and 11.
    ram[0][0][10] = 8'h40;
    ram[0][0][11] = 8'h80;
    line(127, 250, 290);
    line(128, 250, 290);
    line(160, 250, 290);
    line(193, 250, 290);
    line(194, 250, 290);

    // Line start must not join the previous line's last sample.
    ram[0][0][255] = 8'h00;
    ram[0][0][0]   = 8'hC0;
    line(64, 700, 780);
    line(256, 250, 270);
    line(257, 250, 270);
    line(200, 250, 270);

    // Overlapping channels: priority and per-channel enable.
    for (int i = 0; i < (1 << AW); i++) begin
      ram[0][0][i] = 8'h60 + 8'($urandom_range(0, 8));
      ram[1][0][i] = ram[0][0][i];
    end
    set_en(2'b11);
    for (int yy = 160; yy <= 169; yy += 3) line(yy, 250, 420);
    set_en(2'b10);
    for (int yy = 160; yy <= 169; yy += 3) line(yy, 250, 420);

    // Bank latch: mid-frame read_index change holds until next frame start.
    set_en(2'b11);
    bus.read_index = 1'b1;
    step(0, 0, 1'b1);
    for (int xi = 490; xi <= 520; xi++) begin
      if (xi == 500) bus.read_index = 1'b0;
      step(xi, 40, 1'b1);
    end
    chk("bank_hold", 32'(bus.read_address[AW]), 32'd1);
    line(41, 250, 300);
    step(0, 0, 1'b1);
    step(5, 0, 1'b1);
    chk("bank_flip", 32'(bus.read_address[AW]), 32'd0);

    // Asynchronous reset in the middle of a lit line.
    for (int i = 0; i < (1 << AW); i++) ram[0][0][i] = 8'h40;
    set_en(2'b01);
    line(128, 250, 400);
    mid_reset();
    line(128, 401, 450);

    // Randomised frames: random data, enables, rows, spans and valid gaps.
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < (1 << AW); i++) ram[c][k][i] = 8'($urandom);
    for (int n = 0; n < 16; n++) begin
      int ry, xa, xb;
      set_en(NCH'($urandom_range(0, (1 << NCH) - 1)));
      bus.read_index = 1'($urandom);
      step(0, 0, 1'b1);
      ry = $urandom_range(0, 530);
      xa = $urandom_range(240, 700);
      xb = xa + $urandom_range(10, 120);
      for (int xi = xa; xi <= xb; xi++) step(xi, ry, ($urandom_range(0, 7) != 0));
    end

    set_en('0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
